// File: rtl/usb_serial_bridge.sv
// Purpose: CPU register bridge between the 6502 bus and the usb_uart_core byte pipes,
//   with TX/RX FIFOs, status/control/count registers, sticky error flags and a level IRQ.
// Latency: CPU reads are registered (1 cycle); a stream byte is visible on in_data the cycle after its push.
// Backpressure: the TX FIFO drains only on in_valid&in_ready; out_ready drops while RX is full;
//   loopback ties in_*/out_* together combinationally.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cs, we, addr, din, dout        CPU access (one access per cs cycle), registered read data
//   irq                            level interrupt, registered
//   in_data, in_valid, in_ready    bytes toward the host (to usb_uart_core)
//   out_data, out_valid, out_ready bytes from the host (from usb_uart_core)

// Purpose: generic synchronous FIFO with occupancy count and a flush input.
// Latency: a pushed word appears at rdata on the next cycle; rdata shows the head combinationally.
// Backpressure: a push is taken when not full, or when full together with a pop; flush wins over push.
module usb_serial_bridge_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// Purpose: top-level bridge; CPU register file plus TX/RX FIFOs and the loopback mux.
// Latency: dout and irq are registered (1 cycle); stream outputs follow FIFO state with no in_ready path.
// Backpressure: out_ready = !rx_full (held low until the first edge after reset), bypassed in loopback.
module usb_serial_bridge #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic [7:0] in_data,
  output logic       in_valid,
  input  logic       in_ready,
  input  logic [7:0] out_data,
  input  logic       out_valid,
  output logic       out_ready
);
  logic             rx_ie;
  logic             tx_ie;
  logic             loopback;
  logic             tx_ovf;
  logic             rx_ovf;
  logic             init_q;

  logic             acc_rd;
  logic             acc_wr;
  logic             wr_data;
  logic             rd_data;
  logic             wr_status;
  logic             wr_ctrl;
  logic             tx_flush;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_drop;
  logic             lb_ovf;
  logic             rx_ready;
  logic             rx_push;
  logic             irq_next;

  logic [7:0]       tx_head;
  logic [7:0]       rx_head;
  logic [TX_AW:0]   tx_count;
  logic [RX_AW:0]   rx_count;
  logic             tx_empty;
  logic             tx_full;
  logic             rx_empty;
  logic             rx_full;
  logic [7:0]       status_val;
  logic [7:0]       rd_val;

  assign acc_rd    = cs & ~we;
  assign acc_wr    = cs & we;
  assign wr_data   = acc_wr & (addr == 3'd0);
  assign rd_data   = acc_rd & (addr == 3'd0);
  assign wr_status = acc_wr & (addr == 3'd1);
  assign wr_ctrl   = acc_wr & (addr == 3'd2);
  assign tx_flush  = wr_ctrl & din[3];

  // In loopback the FIFOs are frozen on the stream side; only CPU reads still drain RX.
  assign tx_push   = wr_data & ~loopback;
  assign tx_pop    = in_ready & ~loopback;
  assign tx_drop   = tx_push & tx_full & ~tx_pop & ~tx_flush;
  assign lb_ovf    = wr_data & loopback;
  assign rx_ready  = init_q & ~rx_full;
  assign rx_push   = out_valid & rx_ready & ~loopback;

  usb_serial_bridge_fifo #(.AW(TX_AW), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (tx_flush),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (din),
    .rdata (tx_head),
    .count (tx_count),
    .empty (tx_empty),
    .full  (tx_full)
  );

  usb_serial_bridge_fifo #(.AW(RX_AW), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (rx_push),
    .pop   (rd_data),
    .wdata (out_data),
    .rdata (rx_head),
    .count (rx_count),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign in_data   = loopback ? out_data  : tx_head;
  assign in_valid  = loopback ? out_valid : ~tx_empty;
  assign out_ready = loopback ? in_ready  : rx_ready;

  assign status_val = {irq, 2'b00, tx_ovf, rx_ovf, tx_empty, ~tx_full, ~rx_empty};
  assign irq_next   = (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | tx_ovf | rx_ovf;

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      3'd0:    rd_val = rx_empty ? 8'h00 : rx_head;
      3'd1:    rd_val = status_val;
      3'd2:    rd_val = {5'b00000, loopback, tx_ie, rx_ie};
      3'd3:    rd_val = 8'(rx_count);
      3'd4:    rd_val = 8'(tx_count);
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q   <= 1'b0;
      dout     <= 8'h00;
      irq      <= 1'b0;
      rx_ie    <= 1'b0;
      tx_ie    <= 1'b0;
      loopback <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (acc_rd) dout <= rd_val;
      // tx_flush is a pulse and is not stored.
      if (wr_ctrl) {loopback, tx_ie, rx_ie} <= din[2:0];
      // A new set wins over a same-edge write-1-to-clear.
      tx_ovf <= (tx_ovf & ~(wr_status & din[4])) | tx_drop;
      rx_ovf <= (rx_ovf & ~(wr_status & din[3])) | lb_ovf;
      irq    <= irq_next;
    end
  end
endmodule

// File: tb/tb_usb_serial_bridge.sv
// Purpose: self-checking bench for usb_serial_bridge with a queue-based reference model.
// Latency: inputs change 1 time unit after a rising edge, outputs are checked mid-cycle and after the edge.
// Backpressure: host/core handshakes are driven from queues and randomised ready/valid.
module tb_usb_serial_bridge;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  usb_serial_bridge #(.TX_AW(4), .RX_AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .irq       (irq),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [2:0] m_ctrl;
  logic       m_txovf;
  logic       m_rxovf;
  logic       m_irq;
  logic       m_started;
  logic [7:0] m_dout;

  // Bench-side stimulus state
  logic [7:0] hostq[$];
  logic [7:0] got[$];
  logic       last_acc;
  logic       g_ir;

  // Bytes delivered toward the host, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) got.push_back(in_data);
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_ctrl    = 3'b000;
    m_txovf   = 1'b0;
    m_rxovf   = 1'b0;
    m_irq     = 1'b0;
    m_started = 1'b0;
    m_dout    = 8'h00;
  endtask

  // One clock cycle: drive, check stream outputs mid-cycle, advance the model, check registered outputs.
  task automatic cyc(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic ir, input logic ov, input logic [7:0] od);
    logic       loop;
    logic       iv_e;
    logic       or_e;
    logic       irq_n;
    logic [7:0] rd_e;
    cs = c; we = w; addr = a; din = d;
    in_ready = ir; out_valid = ov; out_data = od;
    #3;
    loop = m_ctrl[2];
    iv_e = loop ? ov : (txq.size() != 0);
    or_e = loop ? ir : (m_started && (rxq.size() < RXD));
    check8("in_valid", {7'b0, in_valid}, {7'b0, iv_e});
    if (iv_e) check8("in_data", in_data, loop ? od : txq[0]);
    check8("out_ready", {7'b0, out_ready}, {7'b0, or_e});
    case (a)
      3'd0:    rd_e = (rxq.size() != 0) ? rxq[0] : 8'h00;
      3'd1:    rd_e = {m_irq, 2'b00, m_txovf, m_rxovf, (txq.size() == 0),
                       (txq.size() < TXD), (rxq.size() != 0)};
      3'd2:    rd_e = {5'b00000, m_ctrl};
      3'd3:    rd_e = 8'(rxq.size());
      3'd4:    rd_e = 8'(txq.size());
      default: rd_e = 8'h00;
    endcase
    irq_n = (m_ctrl[0] && rxq.size() != 0) || (m_ctrl[1] && txq.size() == 0) || m_txovf || m_rxovf;
    last_acc = ov && or_e;
    if (c && !w) m_dout = rd_e;
    if (!loop && ir && txq.size() != 0) void'(txq.pop_front());
    if (c && !w && a == 3'd0 && rxq.size() != 0) void'(rxq.pop_front());
    if (!loop && ov && or_e) rxq.push_back(od);
    if (c && w) begin
      case (a)
        3'd0: begin
          if (loop) m_rxovf = 1'b1;
          else if (txq.size() < TXD) txq.push_back(d);
          else m_txovf = 1'b1;
        end
        3'd1: begin
          if (d[4]) m_txovf = 1'b0;
          if (d[3]) m_rxovf = 1'b0;
        end
        3'd2: begin
          m_ctrl = d[2:0];
          if (d[3]) txq.delete();
        end
        default: ;
      endcase
    end
    m_irq = irq_n;
    @(posedge clk);
    #1;
    m_started = 1'b1;
    check8("dout", dout, m_dout);
    check8("irq", {7'b0, irq}, {7'b0, m_irq});
  endtask

  // CPU access with the host streaming from hostq and the core ready from g_ir.
  task automatic step(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d);
    logic       ov;
    logic [7:0] od;
    ov = (hostq.size() != 0);
    od = ov ? hostq[0] : 8'h00;
    cyc(c, w, a, d, g_ir, ov, od);
    if (last_acc) void'(hostq.pop_front());
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rc;
    logic       rw;
    logic [2:0] ra;
    logic [7:0] rdat;

    rst_n = 1'b0;
    cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
    in_ready = 1'b0; out_valid = 1'b0; out_data = 8'h00;
    g_ir = 1'b0;
    model_reset();
    #1;
    check8("rst_dout", dout, 8'h00);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    check8("rst_in_valid", {7'b0, in_valid}, 8'h00);
    check8("rst_out_ready", {7'b0, out_ready}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(3'd1);
    check8("rst_status", dout, 8'h06);

    // TX fill with the core stalled: 17th byte dropped
    g_ir = 1'b0;
    for (int i = 0; i <= 16; i++) wr(3'd0, 8'(i));
    rd(3'd4);
    check8("txcnt_full", dout, 8'd16);
    rd(3'd1);
    check8("tx_ovf_set", {7'b0, dout[4]}, 8'h01);
    got.delete();
    g_ir = 1'b1;
    idle(20);
    check8("tx_drain_count", 8'(got.size()), 8'd16);
    for (int i = 0; i < 16; i++)
      check8("tx_order", (i < got.size()) ? got[i] : 8'hxx, 8'(i));
    rd(3'd4);
    check8("txcnt_empty", dout, 8'd0);
    rd(3'd1);
    check8("status_ovf_sticky", dout, 8'h96);
    wr(3'd1, 8'h10);
    rd(3'd1);
    rd(3'd1);
    check8("status_after_w1c", dout, 8'h06);

    // RX backpressure: host sends 20 bytes, CPU idle
    for (int i = 0; i < 20; i++) hostq.push_back(8'h80 + 8'(i));
    idle(20);
    check8("rx_backpressure", {7'b0, out_ready}, 8'h00);
    rd(3'd3);
    check8("rxcnt_full", dout, 8'd16);
    for (int i = 0; i < 20; i++) begin
      rd(3'd0);
      check8("rx_order", dout, 8'h80 + 8'(i));
    end
    check8("host_drained", 8'(hostq.size()), 8'd0);
    rd(3'd0);
    check8("rx_empty_read", dout, 8'h00);

    // Push to a full TX on the same edge the core accepts
    g_ir = 1'b0;
    for (int i = 0; i < 16; i++) wr(3'd0, 8'hA0 + 8'(i));
    got.delete();
    g_ir = 1'b1;
    wr(3'd0, 8'hEE);
    g_ir = 1'b0;
    rd(3'd4);
    check8("simul_txcnt", dout, 8'd16);
    rd(3'd1);
    check8("simul_no_ovf", {7'b0, dout[4]}, 8'h00);
    g_ir = 1'b1;
    idle(20);
    check8("simul_count", 8'(got.size()), 8'd17);
    check8("simul_last", (got.size() == 17) ? got[16] : 8'hxx, 8'hEE);

    // IRQ: rx_ie then tx_ie
    wr(3'd2, 8'h01);
    hostq.push_back(8'h41);
    idle(1);
    idle(1);
    check8("irq_rx", {7'b0, irq}, 8'h01);
    rd(3'd0);
    check8("irq_rx_data", dout, 8'h41);
    idle(1);
    check8("irq_rx_clear", {7'b0, irq}, 8'h00);
    wr(3'd2, 8'h02);
    idle(1);
    check8("irq_tx_empty", {7'b0, irq}, 8'h01);

    // Loopback with a byte parked in TX
    g_ir = 1'b0;
    wr(3'd0, 8'h33);
    wr(3'd2, 8'h04);
    got.delete();
    hostq.push_back(8'h55);
    hostq.push_back(8'hAA);
    for (int i = 0; i < 20 && hostq.size() != 0; i++) begin
      g_ir = ~g_ir;
      idle(1);
    end
    g_ir = 1'b0;
    check8("lb_count", 8'(got.size()), 8'd2);
    check8("lb_byte0", (got.size() > 0) ? got[0] : 8'hxx, 8'h55);
    check8("lb_byte1", (got.size() > 1) ? got[1] : 8'hxx, 8'hAA);
    rd(3'd4);
    check8("lb_txcnt", dout, 8'd1);
    rd(3'd3);
    check8("lb_rxcnt", dout, 8'd0);
    wr(3'd0, 8'h77);
    rd(3'd1);
    check8("lb_rx_ovf", {7'b0, dout[3]}, 8'h01);
    wr(3'd1, 8'h08);
    wr(3'd2, 8'h00);
    got.delete();
    g_ir = 1'b1;
    idle(3);
    check8("lb_tx_kept", (got.size() == 1) ? got[0] : 8'hxx, 8'h33);

    // Asynchronous reset mid-stream
    g_ir = 1'b0;
    wr(3'd0, 8'h11);
    wr(3'd0, 8'h22);
    hostq.push_back(8'h99);
    rd(3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check8("mid_rst_dout", dout, 8'h00);
    check8("mid_rst_irq", {7'b0, irq}, 8'h00);
    check8("mid_rst_in_valid", {7'b0, in_valid}, 8'h00);
    check8("mid_rst_out_ready", {7'b0, out_ready}, 8'h00);
    model_reset();
    hostq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(3'd1);
    check8("mid_rst_status", dout, 8'h06);
    rd(3'd3);
    check8("mid_rst_rxcnt", dout, 8'd0);
    rd(3'd4);
    check8("mid_rst_txcnt", dout, 8'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rc   = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      rdat = 8'($urandom);
      if (ra == 3'd2) begin
        rdat[2] = ($urandom_range(0, 3) == 0);
        rdat[3] = ($urandom_range(0, 7) == 0);
      end
      cyc(rc, rw, ra, rdat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      if (got.size() > 64) got.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
